// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Single-issue instruction fetch stage with IF/ID register,
//               stall/redirect handling and RUN/FAULT address checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 45
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_nop             = 32'h0000_0013;
    localparam logic [31:0] c_imem_words      = 32'(IMEM_WORDS);
    localparam logic [1:0]  c_cause_none      = 2'b00;
    localparam logic [1:0]  c_cause_range     = 2'b01;
    localparam logic [1:0]  c_cause_misalign  = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic        r_if_id_valid;
    logic [1:0]  r_fault_cause;
    logic [31:0] r_fault_pc;
    logic [31:0] r_fetch_count;

    logic        w_target_aligned;
    logic        w_pc_in_range;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_count_plus1;

    assign w_target_aligned = (redirect_target[1:0] == 2'b00);
    assign w_pc_in_range    = ((r_pc >> 2) < c_imem_words);
    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_count_plus1    = r_fetch_count + 32'd1;

    // Priority inside RUN: redirect, then stall, then a normal fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_if_id_instr <= c_nop;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_valid <= 1'b0;
            r_fault_cause <= c_cause_none;
            r_fault_pc    <= 32'h0000_0000;
            r_fetch_count <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (redirect) begin
                        r_if_id_valid <= 1'b0;
                        r_if_id_instr <= c_nop;
                        if (w_target_aligned) begin
                            r_pc <= redirect_target;
                        end else begin
                            r_state       <= ST_FAULT;
                            r_fault_cause <= c_cause_misalign;
                            r_fault_pc    <= redirect_target;
                        end
                    end else if (!stall) begin
                        if (w_pc_in_range) begin
                            r_if_id_instr <= instr_in;
                            r_if_id_pc    <= r_pc;
                            r_if_id_valid <= 1'b1;
                            r_pc          <= w_pc_plus4;
                            r_fetch_count <= w_count_plus1;
                        end else begin
                            r_state       <= ST_FAULT;
                            r_fault_cause <= c_cause_range;
                            r_fault_pc    <= r_pc;
                            r_if_id_valid <= 1'b0;
                            r_if_id_instr <= c_nop;
                        end
                    end
                end
                ST_FAULT: begin
                    // Stall is ignored here; only a redirect can leave FAULT.
                    r_if_id_valid <= 1'b0;
                    r_if_id_instr <= c_nop;
                    if (redirect) begin
                        if (w_target_aligned) begin
                            r_state       <= ST_RUN;
                            r_pc          <= redirect_target;
                            r_fault_cause <= c_cause_none;
                        end else begin
                            r_fault_cause <= c_cause_misalign;
                            r_fault_pc    <= redirect_target;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;
    assign fault       = (r_state == ST_FAULT);
    assign fault_cause = r_fault_cause;
    assign fault_pc    = r_fault_pc;
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 45, meaning the number of valid 32-bit instruction-memory words.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port pc, output, 32 bits, the fetch address driven to instruction memory (word index = pc>>2).
REQ-006 SHALL have port instr_in, input, 32 bits, the combinational instruction-memory read data for pc.
REQ-007 SHALL have port stall, input, 1 bit, a hold request from decode.
REQ-008 SHALL have port redirect, input, 1 bit, a branch/jump taken strobe.
REQ-009 SHALL have port redirect_target, input, 32 bits, the new fetch address, sampled when redirect=1.
REQ-010 SHALL have port if_id_instr, output, 32 bits, the registered instruction to decode.
REQ-011 SHALL have port if_id_pc, output, 32 bits, the address of if_id_instr.
REQ-012 SHALL have port if_id_valid, output, 1 bit, set when if_id_instr is a real fetched instruction.
REQ-013 SHALL have port fault, output, 1 bit, set while in the FAULT state.
REQ-014 SHALL have port fault_cause, output, 2 bits: 00 none, 01 out-of-range, 10 misaligned.
REQ-015 SHALL have port fault_pc, output, 32 bits, the offending address.
REQ-016 SHALL have port fetch_count, output, 32 bits, the count of instructions accepted into IF/ID.

Function
REQ-017 SHALL implement two states, RUN and FAULT, and resolve each cycle's events in priority order: redirect > stall > normal fetch.
REQ-018 In RUN with redirect=1 and redirect_target[1:0]==0, the block SHALL on the next edge set pc<=redirect_target, if_id_valid<=0, and if_id_instr<=32'h0000_0013 (NOP, flush).
REQ-019 In RUN with redirect=1 and redirect_target[1:0]!=0, the block SHALL go to FAULT with fault_cause=10, fault_pc=redirect_target, pc held, if_id_valid<=0, if_id_instr<=NOP.
REQ-020 In RUN with stall=1 and redirect=0, the block SHALL hold pc, if_id_instr, if_id_pc, if_id_valid and fetch_count unchanged.
REQ-021 In RUN with stall=0, redirect=0 and (pc>>2)<IMEM_WORDS, the block SHALL on the next edge capture if_id_instr<=instr_in, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4, and fetch_count<=fetch_count+1 (latency one cycle from pc to IF/ID).
REQ-022 In RUN with stall=0, redirect=0 and (pc>>2)>=IMEM_WORDS, the block SHALL go to FAULT with fault_cause=01, fault_pc=pc, pc held, if_id_valid<=0, if_id_instr<=NOP.
REQ-023 In FAULT, the block SHALL ignore stall, keep if_id_valid=0, and keep fault=1 with fault_cause/fault_pc frozen.
REQ-024 In FAULT with redirect=1 and an aligned target, the block SHALL return to RUN with pc<=target, fault<=0 and fault_cause<=00; a misaligned target SHALL remain in FAULT with fault_pc updated to that target.
REQ-025 pc+4 and fetch_count SHALL wrap modulo 2^32 without a flag.
REQ-026 The block SHALL assert fault combinationally only from the registered state (fault == state is FAULT).

Reset
REQ-027 While rst=1, the block SHALL immediately set pc=RESET_PC, state=RUN, if_id_instr=32'h0000_0013, if_id_pc=0, if_id_valid=0, fault=0, fault_cause=00, fault_pc=0, and fetch_count=0, regardless of clk.
REQ-028 Reset asserted mid-stall, mid-redirect or in FAULT SHALL override all other inputs.
REQ-029 The first fetch SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-030 Sequential fetch: mem[0..2]=A,B,C, no stall -> edges 1..3 give if_id_instr A,B,C; if_id_pc 0,4,8; valid=1; fetch_count=3.
REQ-031 Stall: stall=1 for 2 cycles after fetching B -> if_id_instr=B and pc=8 are held; C appears one cycle after stall drops.
REQ-032 Redirect with simultaneous stall: redirect=1 to 0x20 while stall=1 -> next edge pc=0x20, if_id_valid=0, if_id_instr=0x00000013; the following edge gives mem[8] at if_id_pc=0x20.
REQ-033 Misaligned redirect to 0x22 -> fault=1, fault_cause=10, fault_pc=0x22; a later redirect to 0x10 -> RUN resumes, fault=0.
REQ-034 Out-of-range: redirect to 0xB4 (word 45) -> next fetch edge gives fault=1, fault_cause=01, fault_pc=0xB4, pc held at 0xB4.
REQ-035 Asynchronous reset asserted mid-cycle in FAULT -> all outputs take REQ-027 values before the next clk edge.
